// File: rtl/fighter_pkg.sv
// Shared widths, health limits and round-state encoding for the fighter health logic.
package fighter_pkg;

  localparam int unsigned HEALTH_W = 5;
  localparam int unsigned DMG_W    = 4;
  localparam logic [HEALTH_W-1:0] MAX_HEALTH = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIGHT = 2'd1,
    KO    = 2'd2
  } state_e;

  // Health never wraps: damage at or above the current value floors at zero.
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] health,
                                                  input logic [DMG_W-1:0]    dmg);
    logic [HEALTH_W-1:0] dmg_ext;
    dmg_ext = {{(HEALTH_W-DMG_W){1'b0}}, dmg};
    return (health > dmg_ext) ? (health - dmg_ext) : {HEALTH_W{1'b0}};
  endfunction

endpackage

// File: rtl/invuln_timer.sv
// Post-hit lockout counter: loaded on an accepted hit, busy until it drains to zero.
module invuln_timer #(
  parameter int unsigned CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_load,
  output logic o_busy
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  // Lockout countdown; a round restart cancels any pending lockout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clear) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_load) begin
      r_cnt <= CW'(CYCLES - 1);
    end else if (r_cnt != {CW{1'b0}}) begin
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_busy = (r_cnt != {CW{1'b0}});

endmodule

// File: rtl/health_tracker.sv
// Round state machine and per-player health bookkeeping with saturating damage,
// invulnerability windows and a timed KO display before the round ends.
module health_tracker
  import fighter_pkg::*;
#(
  parameter int unsigned INVULN_CYCLES  = 50_000_000,
  parameter int unsigned KO_HOLD_CYCLES = 300_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                round_start,
  input  logic                hit_l,
  input  logic [DMG_W-1:0]    dmg_l,
  input  logic                hit_r,
  input  logic [DMG_W-1:0]    dmg_r,
  output logic [HEALTH_W-1:0] curr_health_l,
  output logic [HEALTH_W-1:0] curr_health_r,
  output logic                fight_active,
  output logic                ko_l,
  output logic                ko_r,
  output logic                round_over
);

  localparam int unsigned KW = (KO_HOLD_CYCLES > 1) ? $clog2(KO_HOLD_CYCLES) : 1;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [KW-1:0]       r_ko_cnt;
  logic [KW-1:0]       w_ko_cnt_nxt;
  logic [HEALTH_W-1:0] w_health_l_nxt;
  logic [HEALTH_W-1:0] w_health_r_nxt;
  logic                w_busy_l;
  logic                w_busy_r;
  logic                w_restart;
  logic                w_acc_l;
  logic                w_acc_r;
  logic                w_ko_done;
  logic                w_fight_nxt;
  logic                w_ko_l_nxt;
  logic                w_ko_r_nxt;
  logic                w_round_over_nxt;

  // A restart takes priority over any hit presented in the same cycle.
  assign w_restart = round_start && ((r_state == IDLE) || (r_state == FIGHT));
  assign w_acc_l   = (r_state == FIGHT) && !round_start && hit_l &&
                     (dmg_l != {DMG_W{1'b0}}) && !w_busy_l;
  assign w_acc_r   = (r_state == FIGHT) && !round_start && hit_r &&
                     (dmg_r != {DMG_W{1'b0}}) && !w_busy_r;
  assign w_ko_done = (r_state == KO) && (r_ko_cnt == KW'(KO_HOLD_CYCLES - 1));

  invuln_timer #(.CYCLES(INVULN_CYCLES)) u_invuln_l (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_restart),
    .i_load  (w_acc_l),
    .o_busy  (w_busy_l)
  );

  invuln_timer #(.CYCLES(INVULN_CYCLES)) u_invuln_r (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_restart),
    .i_load  (w_acc_r),
    .o_busy  (w_busy_r)
  );

  // State, health, KO counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_ko_cnt      <= {KW{1'b0}};
      curr_health_l <= MAX_HEALTH;
      curr_health_r <= MAX_HEALTH;
      fight_active  <= 1'b0;
      ko_l          <= 1'b0;
      ko_r          <= 1'b0;
      round_over    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ko_cnt      <= w_ko_cnt_nxt;
      curr_health_l <= w_health_l_nxt;
      curr_health_r <= w_health_r_nxt;
      fight_active  <= w_fight_nxt;
      ko_l          <= w_ko_l_nxt;
      ko_r          <= w_ko_r_nxt;
      round_over    <= w_round_over_nxt;
    end
  end

  // Next state, next health and KO hold counter.
  always_comb begin
    w_state_nxt    = r_state;
    w_ko_cnt_nxt   = {KW{1'b0}};
    w_health_l_nxt = curr_health_l;
    w_health_r_nxt = curr_health_r;
    case (r_state)
      IDLE: begin
        if (round_start) begin
          w_state_nxt    = FIGHT;
          w_health_l_nxt = MAX_HEALTH;
          w_health_r_nxt = MAX_HEALTH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FIGHT: begin
        if (round_start) begin
          w_state_nxt    = FIGHT;
          w_health_l_nxt = MAX_HEALTH;
          w_health_r_nxt = MAX_HEALTH;
        end else begin
          if (w_acc_l) begin
            w_health_l_nxt = sat_sub(curr_health_l, dmg_l);
          end else begin
            w_health_l_nxt = curr_health_l;
          end
          if (w_acc_r) begin
            w_health_r_nxt = sat_sub(curr_health_r, dmg_r);
          end else begin
            w_health_r_nxt = curr_health_r;
          end
          if ((curr_health_l == {HEALTH_W{1'b0}}) || (curr_health_r == {HEALTH_W{1'b0}})) begin
            w_state_nxt = KO;
          end else begin
            w_state_nxt = FIGHT;
          end
        end
      end
      KO: begin
        if (w_ko_done) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt  = KO;
          w_ko_cnt_nxt = r_ko_cnt + KW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Flags are derived from next-state values so the registered copies track the state.
  always_comb begin
    w_fight_nxt      = (w_state_nxt == FIGHT);
    w_ko_l_nxt       = (w_state_nxt == KO) && (w_health_l_nxt == {HEALTH_W{1'b0}});
    w_ko_r_nxt       = (w_state_nxt == KO) && (w_health_r_nxt == {HEALTH_W{1'b0}});
    w_round_over_nxt = w_ko_done;
  end

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker: cycle-level reference model plus literal spot checks.
module tb_health_tracker;

  localparam int INV = 4;
  localparam int KOH = 8;

  logic       clk;
  logic       reset_n;
  logic       round_start;
  logic       hit_l;
  logic [3:0] dmg_l;
  logic       hit_r;
  logic [3:0] dmg_r;
  logic [4:0] curr_health_l;
  logic [4:0] curr_health_r;
  logic       fight_active;
  logic       ko_l;
  logic       ko_r;
  logic       round_over;

  int tests = 0;
  int fails = 0;
  bit running = 0;

  // Reference model: phase flags, healths, lockout end cycles, KO cycles remaining.
  int m_cyc;
  int m_hl, m_hr;
  bit m_fight, m_ko, m_ro;
  int m_ko_left;
  int m_lock_l, m_lock_r;

  health_tracker #(.INVULN_CYCLES(INV), .KO_HOLD_CYCLES(KOH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .round_start   (round_start),
    .hit_l         (hit_l),
    .dmg_l         (dmg_l),
    .hit_r         (hit_r),
    .dmg_r         (dmg_r),
    .curr_health_l (curr_health_l),
    .curr_health_r (curr_health_r),
    .fight_active  (fight_active),
    .ko_l          (ko_l),
    .ko_r          (ko_r),
    .round_over    (round_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_hl = 31; m_hr = 31;
    m_fight = 0; m_ko = 0; m_ro = 0;
    m_ko_left = 0;
    m_lock_l = m_cyc; m_lock_r = m_cyc;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the model advances with the same inputs.
  task automatic step(input bit rs, input bit hl, input int dl, input bit hr, input int dr);
    int nhl, nhr, nko, nll, nlr;
    bit nf, nk, nro;
    round_start = rs; hit_l = hl; dmg_l = 4'(dl); hit_r = hr; dmg_r = 4'(dr);
    nhl = m_hl; nhr = m_hr; nf = m_fight; nk = m_ko; nro = 0;
    nko = m_ko_left; nll = m_lock_l; nlr = m_lock_r;
    if (m_fight) begin
      if (rs) begin
        nhl = 31; nhr = 31; nll = m_cyc; nlr = m_cyc;
      end else begin
        if (hl && dl != 0 && m_cyc >= m_lock_l) begin
          nhl = (m_hl > dl) ? m_hl - dl : 0;
          nll = m_cyc + INV;
        end
        if (hr && dr != 0 && m_cyc >= m_lock_r) begin
          nhr = (m_hr > dr) ? m_hr - dr : 0;
          nlr = m_cyc + INV;
        end
        if (m_hl == 0 || m_hr == 0) begin
          nf = 0; nk = 1; nko = KOH;
        end
      end
    end else if (m_ko) begin
      nko = m_ko_left - 1;
      if (nko == 0) begin
        nk = 0; nro = 1;
      end
    end else if (rs) begin
      nf = 1; nhl = 31; nhr = 31; nll = m_cyc; nlr = m_cyc;
    end
    @(posedge clk);
    #1;
    m_hl = nhl; m_hr = nhr; m_fight = nf; m_ko = nk; m_ro = nro;
    m_ko_left = nko; m_lock_l = nll; m_lock_r = nlr;
    m_cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (running) begin
      tests++;
      if (curr_health_l !== 5'(m_hl) || curr_health_r !== 5'(m_hr) ||
          fight_active !== m_fight || ko_l !== (m_ko && m_hl == 0) ||
          ko_r !== (m_ko && m_hr == 0) || round_over !== m_ro) begin
        fails++;
        $display("FAIL cycle %0d: got hl=%0d hr=%0d fa=%0b kl=%0b kr=%0b ro=%0b expected hl=%0d hr=%0d fa=%0b kl=%0b kr=%0b ro=%0b",
                 m_cyc, curr_health_l, curr_health_r, fight_active, ko_l, ko_r, round_over,
                 m_hl, m_hr, m_fight, m_ko && m_hl == 0, m_ko && m_hr == 0, m_ro);
      end
    end
  end

  initial begin
    m_cyc = 0;
    model_reset();
    reset_n = 1'b0;
    round_start = 1'b0; hit_l = 1'b0; dmg_l = 4'd0; hit_r = 1'b0; dmg_r = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    running = 1;
    chk("reset_health_l", curr_health_l, 31);
    chk("reset_fight", fight_active, 0);

    // Asynchronous reset in the middle of a fight.
    step(1, 0, 0, 0, 0);
    step(0, 1, 5, 1, 2);
    idle(1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_hl", curr_health_l, 31);
    chk("async_rst_hr", curr_health_r, 31);
    chk("async_rst_fight", fight_active, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_cyc++;

    // Hit latency and invulnerability window.
    step(1, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0);
    chk("hit5_hl", curr_health_l, 26);
    idle(1);
    step(0, 1, 7, 0, 0);
    chk("hit_dropped_hl", curr_health_l, 26);
    idle(1);
    step(0, 1, 7, 0, 0);
    chk("hit7_hl", curr_health_l, 19);

    // Walk left health down to 3, then saturate to 0 and KO.
    idle(3);
    step(0, 1, 15, 0, 0);
    idle(3);
    step(0, 1, 1, 0, 0);
    chk("hl_at_3", curr_health_l, 3);
    idle(3);
    step(0, 1, 9, 0, 0);
    chk("saturate_hl", curr_health_l, 0);
    idle(1);
    chk("ko_l_set", ko_l, 1);
    chk("ko_fight_off", fight_active, 0);
    for (int i = 0; i < 7; i++) step(i % 2 == 0, 1, 5, 1, 5);
    chk("ko_hr_frozen", curr_health_r, 31);
    step(1, 1, 3, 1, 3);
    chk("round_over_pulse", round_over, 1);
    step(0, 0, 0, 1, 5);
    chk("round_over_clear", round_over, 0);
    chk("idle_hr_kept", curr_health_r, 31);
    chk("idle_hl_kept", curr_health_l, 0);
    idle(2);

    // Double KO.
    step(1, 0, 0, 0, 0);
    step(0, 1, 15, 1, 15);
    idle(3);
    step(0, 1, 15, 1, 15);
    idle(3);
    step(0, 1, 15, 1, 15);
    chk("double_hl0", curr_health_l, 0);
    chk("double_hr0", curr_health_r, 0);
    idle(1);
    chk("double_ko_l", ko_l, 1);
    chk("double_ko_r", ko_r, 1);
    idle(9);

    // Restart beats a simultaneous hit; zero damage starts no lockout.
    step(1, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0);
    step(1, 0, 0, 1, 4);
    chk("restart_hr", curr_health_r, 31);
    chk("restart_hl", curr_health_l, 31);
    step(0, 1, 2, 0, 0);
    chk("post_restart_hit", curr_health_l, 29);
    step(0, 0, 0, 1, 0);
    chk("zero_dmg_hr", curr_health_r, 31);
    step(0, 0, 0, 1, 3);
    chk("after_zero_hit_hr", curr_health_r, 28);
    idle(2);

    running = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
